// File: rtl/ram_pkg.sv
// Shared RAM interface types: the RAM status encoding and the arbiter state,
// which is exported here so benches can probe it.
package ram_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data ports.
// Data has priority; a starvation counter bounds how long a fetch can wait.
module mem_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              ram_err
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic d_req;
  assign d_req = dREN | dWEN;

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    ram_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (iREN && starve_cnt_q == CNT_MAX) begin
          state_d      = SERVE_I;
          starve_cnt_d = '0;
        end else if (d_req) begin
          state_d = SERVE_D;
          // Only grants that actually make a pending fetch wait are counted
          if (iREN && starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (iREN) begin
          state_d      = SERVE_I;
          starve_cnt_d = '0;
        end
      end

      SERVE_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == ACCESS || ramstate == ERROR) begin
            dwait   = 1'b0;
            ram_err = (ramstate == ERROR);
            state_d = IDLE;
          end
        end
      end

      SERVE_I: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == ACCESS || ramstate == ERROR) begin
            iwait   = 1'b0;
            ram_err = (ramstate == ERROR);
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus a hand-written
// asynchronous reset sequence.
module tb_mem_arbiter;
  import ram_pkg::*;

  localparam logic [31:0] IADDR  = 32'h0000_0100;
  localparam logic [31:0] DADDR  = 32'h0000_0040;
  localparam logic [31:0] DSTORE = 32'h0000_1234;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  // mux: 0 = RAM bus idle, 1 = data port on bus, 2 = instruction port on bus
  typedef struct {
    logic       i, dr, dw;
    ramstate_t  rs;
    arb_state_t st;
    logic [1:0] cnt;
    logic       iw, dwt, ren, wen, err;
    int         mux;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic i, logic dr, logic dw, ramstate_t rs,
                              arb_state_t st, logic [1:0] cnt, logic iw,
                              logic dwt, logic ren, logic wen, logic err,
                              int mux);
    vec_t v;
    v.i = i; v.dr = dr; v.dw = dw; v.rs = rs; v.st = st; v.cnt = cnt;
    v.iw = iw; v.dwt = dwt; v.ren = ren; v.wen = wen; v.err = err; v.mux = mux;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic chk_outputs(input int row, input vec_t v);
    logic [31:0] ea, es;
    ea = (v.mux == 1) ? DADDR : (v.mux == 2) ? IADDR : 32'h0;
    es = (v.mux == 1) ? DSTORE : 32'h0;
    chk("state",    row, 32'(dut.state_q), 32'(v.st));
    chk("starve",   row, 32'(dut.starve_cnt_q), 32'(v.cnt));
    chk("iwait",    row, 32'(iwait), 32'(v.iw));
    chk("dwait",    row, 32'(dwait), 32'(v.dwt));
    chk("ramREN",   row, 32'(ramREN), 32'(v.ren));
    chk("ramWEN",   row, 32'(ramWEN), 32'(v.wen));
    chk("ram_err",  row, 32'(ram_err), 32'(v.err));
    chk("ramaddr",  row, ramaddr, ea);
    chk("ramstore", row, ramstore, es);
    chk("dload",    row, dload, ramload);
    chk("iload",    row, iload, ramload);
  endtask

  initial begin
    // single data read: BUSY x2 then ACCESS
    vecs.push_back(mk(0,1,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));
    vecs.push_back(mk(0,1,0, BUSY,   SERVE_D, 0, 1,1,1,0,0, 1));
    vecs.push_back(mk(0,1,0, BUSY,   SERVE_D, 0, 1,1,1,0,0, 1));
    vecs.push_back(mk(0,1,0, ACCESS, SERVE_D, 0, 1,0,1,0,0, 1));
    vecs.push_back(mk(0,0,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));
    // simultaneous iREN + dWEN, zero-wait RAM; ACCESS in IDLE is ignored
    vecs.push_back(mk(1,0,1, ACCESS, IDLE,    0, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,0,1, ACCESS, SERVE_D, 1, 1,0,0,1,0, 1));
    vecs.push_back(mk(1,0,0, ACCESS, IDLE,    1, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,0,0, ACCESS, SERVE_I, 0, 0,1,1,0,0, 2));
    vecs.push_back(mk(0,0,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));
    // starvation: three data grants, then the fetch wins
    vecs.push_back(mk(1,1,0, ACCESS, IDLE,    0, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,1,0, ACCESS, SERVE_D, 1, 1,0,1,0,0, 1));
    vecs.push_back(mk(1,1,0, ACCESS, IDLE,    1, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,1,0, ACCESS, SERVE_D, 2, 1,0,1,0,0, 1));
    vecs.push_back(mk(1,1,0, ACCESS, IDLE,    2, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,1,0, ACCESS, SERVE_D, 3, 1,0,1,0,0, 1));
    vecs.push_back(mk(1,1,0, ACCESS, IDLE,    3, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,1,0, ACCESS, SERVE_I, 0, 0,1,1,0,0, 2));
    vecs.push_back(mk(0,0,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));
    // error completion on a fetch; ERROR in IDLE is ignored
    vecs.push_back(mk(1,0,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,0,0, ERROR,  SERVE_I, 0, 0,1,1,0,1, 2));
    vecs.push_back(mk(0,0,0, ERROR,  IDLE,    0, 1,1,0,0,0, 0));
    // abort: data read withdrawn while BUSY
    vecs.push_back(mk(0,1,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));
    vecs.push_back(mk(0,1,0, BUSY,   SERVE_D, 0, 1,1,1,0,0, 1));
    vecs.push_back(mk(0,0,0, BUSY,   SERVE_D, 0, 1,1,0,0,0, 0));
    vecs.push_back(mk(0,0,0, FREE,   IDLE,    0, 1,1,0,0,0, 0));

    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = IADDR; daddr = DADDR; dstore = DSTORE;
    ramload = 32'hDEAD_BEEF; ramstate = FREE;
    #12;
    chk_outputs(-1, mk(0,0,0, FREE, IDLE, 0, 1,1,0,0,0, 0));
    $display("reset: state=%0d iwait=%b dwait=%b", dut.state_q, iwait, dwait);

    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      iREN = vecs[k].i; dREN = vecs[k].dr; dWEN = vecs[k].dw;
      ramstate = vecs[k].rs;
      ramload  = 32'hDEAD_BEEF ^ (32'(k) << 4);
      #1;
      chk_outputs(k, vecs[k]);
      $display("row %0d: st=%0d cnt=%0d iwait=%b dwait=%b REN=%b WEN=%b err=%b addr=%h",
               k, dut.state_q, dut.starve_cnt_q, iwait, dwait, ramREN, ramWEN,
               ram_err, ramaddr);
      @(negedge CLK);
    end

    // reset asserted mid-fetch must take effect before any clock edge
    ramload = 32'hCAFE_F00D;
    iREN = 1'b1; ramstate = FREE;
    #1;
    chk("rst_pre_idle", 100, 32'(dut.state_q), 32'(IDLE));
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    chk("rst_serve_i", 101, 32'(dut.state_q), 32'(SERVE_I));
    chk("rst_ren_on",  101, 32'(ramREN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk_outputs(102, mk(1,0,0, BUSY, IDLE, 0, 1,1,0,0,0, 0));
    $display("async reset: state=%0d REN=%b iwait=%b addr=%h",
             dut.state_q, ramREN, iwait, ramaddr);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rel_idle", 103, 32'(dut.state_q), 32'(IDLE));
    @(negedge CLK);
    #1;
    chk("regrant_state", 104, 32'(dut.state_q), 32'(SERVE_I));
    chk("regrant_ren",   104, 32'(ramREN), 32'd1);
    chk("regrant_addr",  104, ramaddr, IADDR);
    $display("regrant: state=%0d REN=%b addr=%h", dut.state_q, ramREN, ramaddr);
    iREN = 1'b0;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Registered arbiter that shares the single-port RAM between the instruction-fetch requester and the data requester. It sits between the two cache ports and the RAM interface. It holds a grant across a multi-cycle RAM access and completes it when the RAM reports `ACCESS`. Data requests have priority, and a starvation counter guarantees instruction fetches are serviced within a bounded number of data grants.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 3, consecutive data grants tolerated while an instruction request is pending

Ports:
- `CLK`  in  1  clock, rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `iREN`  in  1  instruction read request
- `iaddr`  in  ADDR_W  instruction address
- `iwait`  out  1  0 = instruction access completes this cycle
- `iload`  out  DATA_W  instruction read data
- `dREN`, `dWEN`  in  1  data read / write request (both high is illegal; `dWEN` wins)
- `daddr`  in  ADDR_W  data address
- `dstore`  in  DATA_W  data write value
- `dwait`  out  1  0 = data access completes this cycle
- `dload`  out  DATA_W  data read data
- `ramREN`, `ramWEN`  out  1  RAM read / write strobe
- `ramaddr`  out  ADDR_W  RAM address
- `ramstore`  out  DATA_W  RAM write value
- `ramload`  in  DATA_W  RAM read data
- `ramstate`  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR
- `ram_err`  out  1  one-cycle pulse when a granted access ends in ERROR

## Operation
States:
- **IDLE**: RAM strobes are 0 and both waits are 1. The block arbitrates and registers the winner.
  - If `iREN` && `starve_cnt == STARVE_MAX`, go to SERVE_I.
  - Else if `dREN || dWEN`, go to SERVE_D.
  - Else if `iREN`, go to SERVE_I.
  - Else stay in IDLE.
- **SERVE_D**: RAM interface driven combinationally from the data port.
  - `ramaddr = daddr`, `ramstore = dstore`, `ramWEN = dWEN`, `ramREN = dREN & ~dWEN`.
- **SERVE_I**: RAM interface driven combinationally from the instruction port.
  - `ramaddr = iaddr`, `ramREN = 1`, `ramWEN = 0`, `ramstore = 0`.

Completion and abort rules while in a SERVE state:
- `ramstate == ACCESS`: the served port's wait is 0 for that cycle, then go to IDLE.
- `ramstate == ERROR`: the served port's wait is 0, `ram_err = 1`, then go to IDLE.
- Served request withdrawn (REN/WEN low) before completion: abort, drive RAM strobes 0 that cycle, go to IDLE. No wait drops.
- The non-served port's wait stays 1 throughout.

Load data and outputs:
- `dload = ramload` and `iload = ramload` unconditionally. Data is valid only in the requester's wait-low cycle.
- A requester must hold address, data and op stable until its wait drops.

Starvation counter `starve_cnt`, range 0..STARVE_MAX:
- Increments (saturating) on each IDLE→SERVE_D transition taken while `iREN` is high.
- Clears on each IDLE→SERVE_I transition.
- Otherwise holds its value.

## Timing
- Reset values:
  - state IDLE, `starve_cnt` 0
  - `ramREN`, `ramWEN`, `ram_err` 0
  - `ramaddr`, `ramstore` 0
  - `iwait`, `dwait` 1
- Latency: request seen in IDLE at cycle N → strobe asserted at N+1 → wait low in the first cycle at or after N+1 with `ramstate == ACCESS`. With a zero-wait RAM (ACCESS immediately), the wait is low at N+1.
- There is always one IDLE cycle after each completion. Back-to-back accesses are 2 cycles apart minimum, so a requester's held request is never re-granted after its completion edge.
- `ramstate == ACCESS` or `ERROR` in IDLE is ignored (no wait drop, no `ram_err`).
- Simultaneous `iREN` and `dREN`/`dWEN` in IDLE: resolved by the rule above. The loser's request stays pending.
- Asserting `nRST` mid-access returns the block to its reset state immediately (asynchronously). No completion is reported.
- Request changes during a SERVE state do not change the grant, except by withdrawal (abort).

## Structure
- `ramstate_t` (FREE/BUSY/ACCESS/ERROR) comes from `ram_pkg`.
- `arb_state_t` (IDLE, SERVE_I, SERVE_D) is added to `ram_pkg` so benches can probe state.
- There is one sequential process for state and `starve_cnt`, and one combinational process for the RAM mux and waits.
- No sub-module is needed.

## Test plan
- **Single data read**: `dREN=1`, `daddr=0x40`, RAM returns BUSY×2 then ACCESS with `ramload=0xDEADBEEF` → `ramREN=1` from cycle 1; `dwait=0` only at cycle 3 with `dload=0xDEADBEEF`; state IDLE at cycle 4.
- **Simultaneous requests**: `iREN` and `dWEN` together at cycle 0, `dstore=0x1234`, zero-wait RAM → data write served first (`ramWEN=1`, `ramstore=0x1234`); instruction served next after one IDLE; `starve_cnt` 1 then 0.
- **Starvation bound**: `iREN` held while `dREN` is re-requested continuously, STARVE_MAX=3 → exactly 3 data grants, then SERVE_I; `iwait` drops at the next ACCESS.
- **Error completion**: instruction fetch at `iaddr=0x100`, `ramstate=ERROR` → `iwait=0` and `ram_err=1` for exactly one cycle, then IDLE.
- **Abort**: `dREN` dropped while `ramstate=BUSY` in SERVE_D → `ramREN=0` that cycle, no `dwait` drop, IDLE next cycle.
- **Reset mid-access**: `nRST` low during SERVE_I → all outputs at reset values without waiting for a clock edge; after release, a pending `iREN` is granted again 1 cycle later.
